// File: rtl/morse_decoder_pkg.sv
// Shared types and constants for the Morse decoder: FSM states, letter codes
// and the {symbol count, symbols} keys of the decode table.
package morse_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MARK,
      ST_SPACE
   } state_e;

   localparam logic [2:0] LET_A = 3'd0;
   localparam logic [2:0] LET_B = 3'd1;
   localparam logic [2:0] LET_C = 3'd2;
   localparam logic [2:0] LET_D = 3'd3;
   localparam logic [2:0] LET_E = 3'd4;
   localparam logic [2:0] LET_F = 3'd5;
   localparam logic [2:0] LET_G = 3'd6;
   localparam logic [2:0] LET_H = 3'd7;

   // Key = {sym_cnt, symbols}; symbols bit i is the i-th symbol sent, 1 = dash.
   localparam logic [6:0] PAT_A = {3'd2, 4'b0010};
   localparam logic [6:0] PAT_B = {3'd4, 4'b0001};
   localparam logic [6:0] PAT_C = {3'd4, 4'b0101};
   localparam logic [6:0] PAT_D = {3'd3, 4'b0001};
   localparam logic [6:0] PAT_E = {3'd1, 4'b0000};
   localparam logic [6:0] PAT_F = {3'd4, 4'b0100};
   localparam logic [6:0] PAT_G = {3'd3, 4'b0011};
   localparam logic [6:0] PAT_H = {3'd4, 4'b0000};

   typedef struct packed {
      logic       hit;
      logic [2:0] code;
   } decode_t;

   function automatic decode_t decode_letter(logic [2:0] cnt, logic [3:0] syms);
      decode_t res;
      res = '{hit: 1'b1, code: LET_A};
      case ({cnt, syms})
         PAT_A:   res.code = LET_A;
         PAT_B:   res.code = LET_B;
         PAT_C:   res.code = LET_C;
         PAT_D:   res.code = LET_D;
         PAT_E:   res.code = LET_E;
         PAT_F:   res.code = LET_F;
         PAT_G:   res.code = LET_G;
         PAT_H:   res.code = LET_H;
         default: res.hit  = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Unit-rate tick generator: one-cycle tick every TICK_DIV clocks, the first
// one TICK_DIV cycles after reset is released.
module morse_tick_gen #(
   parameter int TICK_DIV = 2500
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = 28;
   localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == '0);
      cnt_d = tick ? RELOAD : cnt_q - 1'b1;
   end

   // NOTE: sequential state always uses non-blocking assignment so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= RELOAD;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/morse_decoder.sv
// Morse decoder for letters A..H: synchronises the line, samples it once per
// unit tick, measures mark/space runs and emits valid or error per letter.
module morse_decoder
   import morse_decoder_pkg::*;
#(
   parameter int TICK_DIV = 2500,
   parameter int MAX_MARK = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       morse_in,
   output logic [2:0] letter,
   output logic       valid,
   output logic       error
);

   localparam int MW = $clog2(MAX_MARK + 1);
   localparam logic [MW-1:0] MARK_SAT  = MW'(MAX_MARK);
   localparam logic [MW-1:0] DOT_LEN   = MW'(1);
   localparam logic [MW-1:0] DASH_LEN  = MW'(3);

   logic          tick;
   logic          sync1_q, sync2_q;
   state_e        state_q, state_d;
   logic [MW-1:0] mark_cnt_q, mark_cnt_d;
   logic [1:0]    space_cnt_q, space_cnt_d;
   logic [2:0]    sym_cnt_q, sym_cnt_d;
   logic [3:0]    symbols_q, symbols_d;
   logic          bad_q, bad_d;
   logic [2:0]    letter_q, letter_d;
   logic          valid_q, valid_d;
   logic          error_q, error_d;
   decode_t       dec;

   morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      mark_cnt_d  = mark_cnt_q;
      space_cnt_d = space_cnt_q;
      sym_cnt_d   = sym_cnt_q;
      symbols_d   = symbols_q;
      bad_d       = bad_q;
      letter_d    = letter_q;
      valid_d     = 1'b0;
      error_d     = 1'b0;
      dec         = decode_letter(sym_cnt_q, symbols_q);

      if (tick) begin
         case (state_q)
            ST_IDLE: begin
               if (sync2_q) begin
                  state_d    = ST_MARK;
                  mark_cnt_d = DOT_LEN;
               end
            end
            ST_MARK: begin
               if (sync2_q) begin
                  if (mark_cnt_q != MARK_SAT) mark_cnt_d = mark_cnt_q + 1'b1;
               end else begin
                  state_d     = ST_SPACE;
                  space_cnt_d = 2'd1;
                  if (mark_cnt_q == DOT_LEN || mark_cnt_q == DASH_LEN) begin
                     if (sym_cnt_q == 3'd4) begin
                        bad_d = 1'b1;
                     end else begin
                        symbols_d[sym_cnt_q[1:0]] = (mark_cnt_q == DASH_LEN);
                        sym_cnt_d = sym_cnt_q + 1'b1;
                     end
                  end else begin
                     bad_d = 1'b1;
                  end
               end
            end
            ST_SPACE: begin
               if (sync2_q) begin
                  state_d    = ST_MARK;
                  mark_cnt_d = DOT_LEN;
                  if (space_cnt_q == 2'd2) bad_d = 1'b1;
               end else if (space_cnt_q == 2'd2) begin
                  // Third space unit: the letter is complete.
                  state_d     = ST_IDLE;
                  space_cnt_d = 2'd0;
                  if (!bad_q && dec.hit) begin
                     letter_d = dec.code;
                     valid_d  = 1'b1;
                  end else begin
                     error_d = 1'b1;
                  end
                  symbols_d = '0;
                  sym_cnt_d = '0;
                  bad_d     = 1'b0;
               end else begin
                  space_cnt_d = space_cnt_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         state_q     <= ST_IDLE;
         mark_cnt_q  <= '0;
         space_cnt_q <= '0;
         sym_cnt_q   <= '0;
         symbols_q   <= '0;
         bad_q       <= 1'b0;
         letter_q    <= LET_A;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         sync1_q     <= morse_in;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         mark_cnt_q  <= mark_cnt_d;
         space_cnt_q <= space_cnt_d;
         sym_cnt_q   <= sym_cnt_d;
         symbols_q   <= symbols_d;
         bad_q       <= bad_d;
         letter_q    <= letter_d;
         valid_q     <= valid_d;
         error_q     <= error_d;
      end
   end

   assign letter = letter_q;
   assign valid  = valid_q;
   assign error  = error_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: letters are described as mark/gap
// run lists, expected outcomes come from a string-level Morse model.
module tb_morse_decoder;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       morse_in;
   logic [2:0] letter;
   logic       valid;
   logic       error;

   always #5 clk = ~clk;

   morse_decoder #(.TICK_DIV(TD), .MAX_MARK(7)) dut (
      .clk      (clk),
      .rst      (rst),
      .morse_in (morse_in),
      .letter   (letter),
      .valid    (valid),
      .error    (error)
   );

   typedef struct {
      bit         is_err;
      logic [2:0] code;
   } exp_t;

   exp_t       sb[$];
   int         checks   = 0;
   int         failures = 0;
   logic [2:0] held_letter;
   string      table_s[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
   int         marks[12];
   int         gaps[12];
   int         nsym;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive the line for n units; called and returning on a falling edge.
   task automatic drive_units(input bit v, input int n);
      repeat (n * TD) begin
         morse_in = v;
         @(negedge clk);
      end
   endtask

   // Reference: turn runs into a dot/dash string, apply the letter rules,
   // then look the string up in the table.
   function automatic exp_t model();
      exp_t  e;
      string s   = "";
      bit    bad = 1'b0;
      int    idx = -1;
      for (int i = 0; i < nsym; i++) begin
         if (marks[i] == 1 || marks[i] == 3) begin
            if (s.len() == 4) bad = 1'b1;
            else s = {s, (marks[i] == 3) ? "-" : "."};
         end else begin
            bad = 1'b1;
         end
         if (i < nsym - 1 && gaps[i] == 2) bad = 1'b1;
      end
      for (int k = 0; k < 8; k++) if (table_s[k] == s) idx = k;
      if (!bad && idx >= 0) begin
         e.is_err = 1'b0;
         e.code   = 3'(idx);
      end else begin
         e.is_err = 1'b1;
         e.code   = held_letter;
      end
      return e;
   endfunction

   task automatic load_pattern(input string p);
      nsym = p.len();
      for (int i = 0; i < nsym; i++) begin
         marks[i] = (p[i] == 8'h2D) ? 3 : 1;
         gaps[i]  = 1;
      end
   endtask

   task automatic send_letter();
      exp_t e;
      e = model();
      if (!e.is_err) held_letter = e.code;
      sb.push_back(e);
      for (int i = 0; i < nsym; i++) begin
         drive_units(1'b1, marks[i]);
         if (i < nsym - 1) drive_units(1'b0, gaps[i]);
      end
      drive_units(1'b0, 3);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", 32'(sb.size()), 0);
   endtask

   // Monitor: every pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && (valid || error)) begin
            check("valid_error_exclusive", 32'(valid & error), 0);
            if (sb.size() == 0) begin
               check("unexpected_pulse", {30'd0, valid, error}, 0);
            end else begin
               e = sb.pop_front();
               check("pulse_is_error", 32'(error), 32'(e.is_err));
               check("letter_value", 32'(letter), 32'(e.code));
            end
         end
      end
   end

   initial begin
      rst         = 1'b1;
      morse_in    = 1'b0;
      held_letter = 3'd0;
      #1;
      check("reset_letter_async", 32'(letter), 0);
      repeat (3) @(negedge clk);
      check("reset_letter", 32'(letter), 0);
      check("reset_valid", 32'(valid), 0);
      check("reset_error", 32'(error), 0);
      rst = 1'b0;
      drive_units(1'b0, 2);

      // Single A with trailing idle.
      load_pattern(".-");
      send_letter();
      drive_units(1'b0, 2);

      // All eight letters back to back.
      for (int i = 0; i < 8; i++) begin
         load_pattern(table_s[i]);
         send_letter();
      end
      drive_units(1'b0, 2);

      // Malformed 2-unit mark.
      nsym     = 1;
      marks[0] = 2;
      send_letter();

      // Five dots.
      load_pattern(".....");
      send_letter();

      // 2-unit intra-letter space, then a clean letter.
      load_pattern(".--.");
      gaps[1] = 2;
      send_letter();
      load_pattern("--.");
      send_letter();

      // Line stuck high well past saturation.
      nsym     = 1;
      marks[0] = 12;
      send_letter();
      drain();

      // Reset in the middle of a dash, then E.
      morse_in = 1'b1;
      repeat (TD + 2) @(negedge clk);
      rst = 1'b1;
      morse_in = 1'b0;
      @(negedge clk);
      check("midreset_letter", 32'(letter), 0);
      check("midreset_valid", 32'(valid), 0);
      held_letter = 3'd0;
      rst = 1'b0;
      drive_units(1'b0, 2);
      load_pattern(".");
      send_letter();
      drain();

      // Randomised mix of legal and malformed letters.
      repeat (40) begin
         if ($urandom_range(0, 9) < 6) begin
            load_pattern(table_s[$urandom_range(0, 7)]);
         end else begin
            nsym = $urandom_range(1, 6);
            for (int i = 0; i < nsym; i++) begin
               marks[i] = $urandom_range(1, 4);
               gaps[i]  = $urandom_range(1, 2);
            end
         end
         send_letter();
         drive_units(1'b0, $urandom_range(0, 2));
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
